// File: rtl/corelet_ctrl.sv
// Corelet instruction sequencer: expands a start pulse plus job descriptor into the
// per-cycle 39-bit inst stream (weight xfer/load, flush, act xfer, execute, OFIFO drain).
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         n_kij,
    input  logic [6:0]         n_act,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] a_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic               relu_en,
    input  logic               ofifo_valid,
    output logic [38:0]        inst,
    output logic               busy,
    output logic               done,
    output logic [3:0]         kij_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_WXFER, S_WLOAD, S_FLUSH, S_AXFER, S_EXEC, S_DRAIN, S_DONE
    } state_t;

    localparam logic [38:0] IDLE_WORD = 39'h1_800C_0000;
    localparam logic [7:0]  COL_N     = 8'(col);
    localparam logic [7:0]  COL_M1    = 8'(col - 1);
    localparam logic [7:0]  FLUSH_M1  = 8'(row + col - 1);

    state_t               state, state_nxt;
    logic [7:0]           cnt;
    logic [3:0]           kij;
    logic [3:0]           n_kij_q;
    logic [6:0]           n_act_q;
    logic [addr_bw-1:0]   w_ptr;
    logic [addr_bw-1:0]   a_base_q;
    logic [addr_bw-1:0]   p_ptr;
    logic                 relu_q;
    logic                 xrd, ofrd;
    logic                 xrd_d, ofrd_d;
    logic [38:0]          inst_nxt;
    logic                 empty_job;
    logic                 last_kij;
    logic [7:0]           act_n, act_m1;

    assign empty_job = (n_kij_q == 4'd0) || (n_act_q == 7'd0);
    assign last_kij  = (kij == n_kij_q - 4'd1);
    assign act_n     = {1'b0, n_act_q};
    assign act_m1    = act_n - 8'd1;
    assign kij_idx   = kij;

    // State register plus the running counters that travel with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            kij      <= '0;
            n_kij_q  <= '0;
            n_act_q  <= '0;
            w_ptr    <= '0;
            a_base_q <= '0;
            p_ptr    <= '0;
            relu_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if (state != S_IDLE && (state != S_DRAIN || ofifo_valid))
                cnt <= cnt + 8'd1;

            if (state == S_IDLE && start) begin
                n_kij_q  <= n_kij;
                n_act_q  <= n_act;
                w_ptr    <= w_base;
                a_base_q <= a_base;
                p_ptr    <= p_base;
                relu_q   <= relu_en;
                kij      <= '0;
            end
            // Weight addresses for consecutive kij are contiguous, so one pointer suffices
            if (state == S_WXFER && xrd)
                w_ptr <= w_ptr + addr_bw'(1);
            if (ofrd_d)
                p_ptr <= p_ptr + addr_bw'(1);
            if (state == S_DRAIN && state_nxt == S_WXFER)
                kij <= kij + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WXFER;
            S_WXFER: begin
                if (empty_job)         state_nxt = S_DONE;
                else if (cnt == COL_N) state_nxt = S_WLOAD;
            end
            S_WLOAD: if (cnt == COL_M1)   state_nxt = S_FLUSH;
            S_FLUSH: if (cnt == FLUSH_M1) state_nxt = S_AXFER;
            S_AXFER: if (cnt == act_n)    state_nxt = S_EXEC;
            S_EXEC:  if (cnt == act_m1)   state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (ofifo_valid && cnt == act_m1)
                    state_nxt = last_kij ? S_DONE : S_WXFER;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        inst_nxt = IDLE_WORD;
        xrd      = 1'b0;
        ofrd     = 1'b0;
        case (state)
            S_WXFER: begin
                if (!empty_job && cnt < COL_N) begin
                    xrd            = 1'b1;
                    inst_nxt[19]   = 1'b0;
                    inst_nxt[17:7] = w_ptr;
                end
            end
            S_WLOAD: begin
                inst_nxt[3] = 1'b1;
                inst_nxt[0] = 1'b1;
            end
            S_AXFER: begin
                if (cnt < act_n) begin
                    xrd            = 1'b1;
                    inst_nxt[19]   = 1'b0;
                    inst_nxt[17:7] = a_base_q + addr_bw'(cnt);
                end
            end
            S_EXEC: begin
                inst_nxt[3] = 1'b1;
                inst_nxt[1] = 1'b1;
            end
            S_DRAIN: begin
                if (ofifo_valid) begin
                    ofrd        = 1'b1;
                    inst_nxt[6] = 1'b1;
                end
            end
            default: ;
        endcase
        if (state != S_IDLE && state != S_DONE)
            inst_nxt[37] = relu_q;
        // xmem data and OFIFO rows arrive one cycle after their read, so the
        // matching L0 write and pmem write ride on the following word
        inst_nxt[2] = xrd_d;
        if (ofrd_d) begin
            inst_nxt[32]    = 1'b0;
            inst_nxt[31]    = 1'b0;
            inst_nxt[30:20] = p_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst   <= IDLE_WORD;
            busy   <= 1'b0;
            done   <= 1'b0;
            xrd_d  <= 1'b0;
            ofrd_d <= 1'b0;
        end else begin
            inst   <= inst_nxt;
            busy   <= (state != S_IDLE) && (state != S_DONE);
            done   <= (state == S_DONE);
            xrd_d  <= xrd;
            ofrd_d <= ofrd;
        end
    end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Randomized bench for corelet_ctrl: an action-list model builds the expected inst
// stream per job, which is compared word by word together with busy/done/kij_idx.
module tb_corelet_ctrl;

    localparam int ROW  = 8;
    localparam int COL  = 8;
    localparam int AW   = 11;
    localparam int MAXC = 2048;
    localparam logic [38:0] IDLE_W = 39'h1_800C_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    n_kij = '0;
    logic [6:0]    n_act = '0;
    logic [AW-1:0] w_base = '0;
    logic [AW-1:0] a_base = '0;
    logic [AW-1:0] p_base = '0;
    logic          relu_en = 1'b0;
    logic          ofifo_valid = 1'b0;
    logic [38:0]   inst;
    logic          busy;
    logic          done;
    logic [3:0]    kij_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    corelet_ctrl #(.row(ROW), .col(COL), .addr_bw(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .n_kij(n_kij), .n_act(n_act),
        .w_base(w_base), .a_base(a_base), .p_base(p_base), .relu_en(relu_en),
        .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done), .kij_idx(kij_idx)
    );

    // Per-cycle actions of the job (index = cycle after the accepted start)
    bit            m_rd   [MAXC];
    logic [AW-1:0] m_addr [MAXC];
    bit            m_l0rd [MAXC];
    bit            m_ld   [MAXC];
    bit            m_ex   [MAXC];
    bit            m_ofr  [MAXC];
    bit            m_valid[MAXC];
    int            m_kij  [MAXC];
    logic [38:0]   e_inst [MAXC];
    bit            e_busy [MAXC];
    bit            e_done [MAXC];
    int            e_kij  [MAXC];
    int            njob;
    int            ntot;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit drain_valid(input int vmode, input int k);
        case (vmode)
            0:       return 1'b1;
            2:       return (k % 4 == 0) || (k % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic bit other_valid(input int vmode);
        return (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    task automatic add_cyc(input bit rd, input int addr, input bit l0rd, input bit ld,
                           input bit ex, input bit ofr, input bit v, input int kij);
        m_rd[njob]    = rd;
        m_addr[njob]  = AW'(addr);
        m_l0rd[njob]  = l0rd;
        m_ld[njob]    = ld;
        m_ex[njob]    = ex;
        m_ofr[njob]   = ofr;
        m_valid[njob] = v;
        m_kij[njob]   = kij;
        njob++;
    endtask

    task automatic build(input int nk, input int na, input int wb, input int ab,
                         input int pb, input bit rl, input int vmode);
        int wr;
        int k;
        int dc;
        bit v;
        logic [38:0] w;
        njob = 0;
        if (nk == 0 || na == 0) begin
            add_cyc(0, 0, 0, 0, 0, 0, other_valid(vmode), 0);
        end else begin
            for (int j = 0; j < nk; j++) begin
                for (int i = 0; i <= COL; i++)
                    add_cyc(i < COL, wb + j * COL + i, 0, 0, 0, 0, other_valid(vmode), j);
                for (int i = 0; i < COL; i++)
                    add_cyc(0, 0, 1, 1, 0, 0, other_valid(vmode), j);
                for (int i = 0; i < ROW + COL; i++)
                    add_cyc(0, 0, 0, 0, 0, 0, other_valid(vmode), j);
                for (int i = 0; i <= na; i++)
                    add_cyc(i < na, ab + i, 0, 0, 0, 0, other_valid(vmode), j);
                for (int i = 0; i < na; i++)
                    add_cyc(0, 0, 1, 0, 1, 0, other_valid(vmode), j);
                k  = 0;
                dc = 0;
                while (k < na) begin
                    v = drain_valid(vmode, dc);
                    dc++;
                    add_cyc(0, 0, 0, 0, 0, v, v, j);
                    if (v) k++;
                end
            end
        end
        ntot = njob + 1;
        m_valid[njob] = 1'b0;
        wr = 0;
        for (int c = 0; c < ntot; c++) begin
            w = IDLE_W;
            if (c < njob) begin
                if (m_rd[c]) begin
                    w[19]   = 1'b0;
                    w[17:7] = m_addr[c];
                end
                w[3]  = m_l0rd[c];
                w[0]  = m_ld[c];
                w[1]  = m_ex[c];
                w[6]  = m_ofr[c];
                w[37] = rl;
            end
            if (c > 0 && m_rd[c-1]) w[2] = 1'b1;
            if (c > 0 && m_ofr[c-1]) begin
                w[32]    = 1'b0;
                w[31]    = 1'b0;
                w[30:20] = AW'(pb + wr);
                wr++;
            end
            e_inst[c] = w;
            e_busy[c] = (c < njob);
            e_done[c] = (c == njob);
            e_kij[c]  = (c + 1 < njob) ? m_kij[c+1] : m_kij[njob-1];
        end
    endtask

    task automatic run_job(input int nk, input int na, input int wb, input int ab,
                           input int pb, input bit rl, input int vmode, input bit hold,
                           input int rst_at, input int exp_lat);
        int lat;
        bit aborted;
        lat     = -1;
        aborted = 1'b0;
        build(nk, na, wb, ab, pb, rl, vmode);
        @(posedge clk); #1;
        n_kij   = 4'(nk);
        n_act   = 7'(na);
        w_base  = AW'(wb);
        a_base  = AW'(ab);
        p_base  = AW'(pb);
        relu_en = rl;
        start   = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        n_kij       = 4'($urandom);
        n_act       = 7'($urandom);
        w_base      = AW'($urandom);
        a_base      = AW'($urandom);
        p_base      = AW'($urandom);
        relu_en     = ~rl;
        ofifo_valid = m_valid[0];
        for (int c = 0; c < ntot && !aborted; c++) begin
            @(posedge clk); #1;
            check("inst", 64'(inst), 64'(e_inst[c]));
            check("busy", 64'(busy), 64'(e_busy[c]));
            check("done", 64'(done), 64'(e_done[c]));
            check("kij_idx", 64'(kij_idx), 64'(e_kij[c]));
            if (done === 1'b1 && lat < 0) lat = c + 1;
            if (c == rst_at) begin
                #2;
                reset       = 1'b0;
                start       = 1'b0;
                ofifo_valid = 1'b0;
                #1;
                check("rst_inst", 64'(inst), 64'(IDLE_W));
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                check("rst_kij", 64'(kij_idx), 64'd0);
                repeat (3) begin
                    @(posedge clk); #1;
                    check("rst_hold_inst", 64'(inst), 64'(IDLE_W));
                    check("rst_hold_done", 64'(done), 64'd0);
                end
                @(negedge clk);
                reset   = 1'b1;
                aborted = 1'b1;
            end else begin
                ofifo_valid = (c + 1 < ntot) ? m_valid[c+1] : 1'b0;
                if (c == ntot - 1) start = 1'b0;
            end
        end
        if (!aborted) begin
            if (exp_lat > 0) check("done_latency", 64'(lat), 64'(exp_lat));
            @(posedge clk); #1;
            check("post_inst", 64'(inst), 64'(IDLE_W));
            check("post_busy", 64'(busy), 64'd0);
            check("post_done", 64'(done), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_inst", 64'(inst), 64'(IDLE_W));
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_kij", 64'(kij_idx), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_job(1, 4, 0, 16, 0, 1'b0, 0, 1'b0, -1, 47);
        run_job(3, 2, 0, 40, 100, 1'b1, 0, 1'b0, -1, -1);
        run_job(2, 3, 5, 64, 10, 1'b0, 2, 1'b0, -1, -1);
        run_job(1, 4, 0, 16, 0, 1'b1, 1, 1'b0, 9 + 8 + 16 + 5 + 1, -1);
        run_job(2, 3, 7, 30, 50, 1'b1, 1, 1'b0, -1, -1);
        run_job(2, 2, 3, 20, 0, 1'b0, 1, 1'b1, -1, -1);
        run_job(3, 0, 0, 0, 0, 1'b1, 1, 1'b0, -1, 2);
        run_job(0, 5, 0, 0, 0, 1'b0, 1, 1'b1, -1, 2);
        run_job(1, 4, 100, 0, 2046, 1'b0, 0, 1'b0, -1, -1);
        run_job(2, 4, 2040, 2045, 2047, 1'b1, 1, 1'b0, -1, -1);
        for (int r = 0; r < 4; r++)
            run_job(int'($urandom_range(1, 3)), int'($urandom_range(1, 10)),
                    int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                    int'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, 2)), 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
